// File: rtl/proc_run_defs.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_defs (package)
// Description : Shared state encodings, defaults and helpers for the
//               processor run monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_run_defs;

    localparam int unsigned RESET_CYCLES_DEFAULT   = 2;
    localparam logic [15:0] WATCHDOG_LIMIT_DEFAULT = 16'h00FF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST      = 3'd1;
    localparam logic [2:0] ST_WAIT_CHK = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_TIMEOUT  = 3'd4;

    typedef struct packed {
        logic [63:0] endpc;
        logic [63:0] expected;
    } checkpoint_t;

    // Result counters stick at all-ones rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : run_watchdog
// Description : Counts RUN cycles spent without reaching the checkpoint PC.
// Revision    : 1.0 - initial release
// ============================================================================
module run_watchdog
    import proc_run_defs::*;
#(
    parameter logic [15:0] LIMIT = WATCHDOG_LIMIT_DEFAULT
) (
    input  logic CLK,
    input  logic resetl,
    input  logic clear,
    input  logic enable,
    output logic limit_reached
);

    logic [15:0] count;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign limit_reached = (count == (LIMIT - 16'd1));

endmodule
`default_nettype wire

// File: rtl/proc_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_monitor
// Description : Resets a processor, feeds it checkpoints and checks the
//               register-writeback value when each checkpoint PC is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_run_monitor
    import proc_run_defs::*;
#(
    parameter int unsigned RESET_CYCLES   = RESET_CYCLES_DEFAULT,
    parameter logic [15:0] WATCHDOG_LIMIT = WATCHDOG_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [63:0] start_pc_in,
    input  logic        chk_valid,
    output logic        chk_ready,
    input  logic [63:0] chk_endpc,
    input  logic [63:0] chk_expected,
    input  logic [63:0] currentpc,
    input  logic [63:0] MemtoRegOut,
    output logic        proc_resetl,
    output logic [63:0] startpc,
    output logic        busy,
    output logic        result_valid,
    output logic        result_pass,
    output logic        timeout,
    output logic [7:0]  pass_count,
    output logic [7:0]  check_count
);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [7:0]  rst_cnt;
    checkpoint_t chk_q;

    logic accept;
    logic result_go;
    logic hit;
    logic rst_last;
    logic wd_limit;
    logic cmp_pass;

    assign hit      = (currentpc >= chk_q.endpc);
    assign rst_last = (rst_cnt == 8'(RESET_CYCLES - 1));
    assign cmp_pass = (MemtoRegOut == chk_q.expected);

    // start overrides every transition, including a pending checkpoint.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        result_go  = 1'b0;
        if (start) begin
            state_next = ST_RST;
        end else begin
            case (state)
                ST_IDLE:     state_next = ST_IDLE;
                ST_RST:      if (rst_last) state_next = ST_WAIT_CHK;
                ST_WAIT_CHK: begin
                    if (chk_valid) begin
                        accept     = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        result_go  = 1'b1;
                        state_next = ST_WAIT_CHK;
                    end else if (wd_limit) begin
                        state_next = ST_TIMEOUT;
                    end
                end
                ST_TIMEOUT:  state_next = ST_TIMEOUT;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    run_watchdog #(
        .LIMIT (WATCHDOG_LIMIT)
    ) u_watchdog (
        .CLK           (CLK),
        .resetl        (resetl),
        .clear         (accept | start),
        .enable        ((state == ST_RUN) & ~hit & ~start),
        .limit_reached (wd_limit)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state        <= ST_IDLE;
            rst_cnt      <= 8'd0;
            chk_q        <= '0;
            proc_resetl  <= 1'b1;
            startpc      <= 64'd0;
            busy         <= 1'b0;
            chk_ready    <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            timeout      <= 1'b0;
            pass_count   <= 8'd0;
            check_count  <= 8'd0;
        end else begin
            state        <= state_next;
            proc_resetl  <= (state_next != ST_RST);
            busy         <= (state_next == ST_RST) || (state_next == ST_WAIT_CHK) ||
                            (state_next == ST_RUN);
            chk_ready    <= (state_next == ST_WAIT_CHK);
            result_valid <= result_go;
            if (start) begin
                startpc     <= start_pc_in;
                rst_cnt     <= 8'd0;
                pass_count  <= 8'd0;
                check_count <= 8'd0;
                timeout     <= 1'b0;
                result_pass <= 1'b0;
            end else begin
                if (state == ST_RST) begin
                    rst_cnt <= rst_cnt + 8'd1;
                end
                if (accept) begin
                    chk_q.endpc    <= chk_endpc;
                    chk_q.expected <= chk_expected;
                end
                if (result_go) begin
                    result_pass <= cmp_pass;
                    check_count <= sat_inc8(check_count);
                    if (cmp_pass) begin
                        pass_count <= sat_inc8(pass_count);
                    end
                end
                if (state_next == ST_TIMEOUT) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/proc_run_monitor.md
PROC_RUN_MONITOR -- requirements
Module: proc_run_monitor

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: number of cycles proc_resetl is held low per start.
REQ-002 SHALL have parameter WATCHDOG_LIMIT, default 16'h00FF: number of RUN cycles allowed per checkpoint.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port resetl, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to (re)start the processor.
REQ-006 SHALL have port start_pc_in, input, 64 bits: PC to load on start.
REQ-007 SHALL have ports chk_valid (input, 1), chk_ready (output, 1), chk_endpc (input, 64) and chk_expected (input, 64): the checkpoint handshake.
REQ-008 SHALL have ports currentpc (input, 64) and MemtoRegOut (input, 64): observed from the processor.
REQ-009 SHALL have ports proc_resetl (output, 1) and startpc (output, 64): driven to the processor.
REQ-010 SHALL have ports busy, result_valid, result_pass and timeout (outputs, 1 bit each) and pass_count, check_count (outputs, 8 bits each).

Function
REQ-011 SHALL implement states IDLE, RST, WAIT_CHK, RUN and TIMEOUT.
REQ-012 IDLE: proc_resetl=1, busy=0, chk_ready=0.
REQ-013 start in any state SHALL go to RST next cycle, latch start_pc_in into startpc, and clear pass_count, check_count and timeout.
REQ-014 start SHALL win over a simultaneous chk_valid, and that checkpoint SHALL NOT be accepted.
REQ-015 RST SHALL drive proc_resetl=0 for exactly RESET_CYCLES cycles, then go to WAIT_CHK with proc_resetl=1.
REQ-016 WAIT_CHK SHALL drive chk_ready=1; chk_ready SHALL be 0 in every other state.
REQ-017 On chk_valid&&chk_ready, SHALL latch chk_endpc/chk_expected, clear the watchdog counter, and enter RUN.
REQ-018 A hit SHALL be an unsigned comparison currentpc >= latched endpc, sampled at a rising edge.
REQ-019 In RUN, the cycle a hit is sampled SHALL register a compare of MemtoRegOut == latched expected, full 64 bits.
REQ-020 The cycle after a hit: result_valid=1 for exactly one cycle, result_pass = compare result, check_count+1, pass_count+1 if pass, state WAIT_CHK.
REQ-021 result_pass SHALL hold its value until the next result_valid or start.
REQ-022 Each RUN cycle without a hit SHALL increment the watchdog counter.
REQ-023 When the counter reaches WATCHDOG_LIMIT-1 without a hit, the next state SHALL be TIMEOUT.
REQ-024 A hit in the same cycle as the limit SHALL take precedence over timeout.
REQ-025 TIMEOUT SHALL assert sticky timeout=1, keep proc_resetl=1, and leave only on start or reset.
REQ-026 pass_count and check_count SHALL saturate at 8'hFF and never wrap.
REQ-027 busy SHALL be 1 in RST, WAIT_CHK and RUN.
REQ-028 The processor SHALL continue running in WAIT_CHK (no reset); consecutive checkpoints SHALL share one program run.

Reset
REQ-029 resetl low SHALL asynchronously force IDLE with proc_resetl=1, startpc=0, busy=0, chk_ready=0, result_valid=0, result_pass=0, timeout=0, pass_count=0, check_count=0 and watchdog counter=0.
REQ-030 Reset during RST or RUN SHALL abandon the run and discard any latched checkpoint.
REQ-031 After resetl deasserts, the block SHALL stay in IDLE until start.

Structure
REQ-032 State encodings and the RESET_CYCLES/WATCHDOG_LIMIT defaults SHALL live in the shared defines file proc_run_defs.
REQ-033 The watchdog counter (clear, enable, limit-reached) SHALL be the sub-module run_watchdog.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Start with start_pc_in=0; checkpoint (endpc 0x30, expected 0xF); model reaches PC 0x30 with MemtoRegOut=0xF -> proc_resetl low 2 cycles, one result_valid with result_pass=1, pass_count=1.
REQ-036 Continue with checkpoint (0x54, 0x123456789abcdef0) without a new start -> no proc_resetl pulse, result_pass=1, pass_count=2, check_count=2.
REQ-037 Checkpoint (0x30, 0xF) with MemtoRegOut=0xE at the hit -> result_pass=0, pass_count=0, check_count=1.
REQ-038 currentpc stuck at 0x10 with endpc 0x30 -> TIMEOUT entered after 255 RUN cycles, timeout=1, busy=0; a later start clears timeout.
REQ-039 resetl pulsed low mid-RUN -> all outputs at reset values immediately; start asserted together with chk_valid in WAIT_CHK -> RST entered and checkpoint not accepted.
